// File: rtl/sub_serial_arbiter.sv
// sub_serial_arbiter: round-robin shares one byte subtractor between two requesters,
// executing a wide a-b-bin LSB-first with a registered borrow.

module fullsubtractor_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] d,
  output logic       bout
);
  logic [8:0] br;
  assign br[0] = bin;
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end
  assign bout = br[8];
endmodule

module sub_serial_arbiter #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_bin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_bin,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] res_d,
  output logic                res_bout,
  output logic                res_id,
  output logic                busy
);
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    last_q, last_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    brw_q, brw_d;
  logic [NBYTES-1:0][7:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic                    bout_q, bout_d, id_q, id_d;
  logic                    gnt0, gnt1, idle, last_byte;
  logic [7:0]              sd;
  logic                    sbout;

  fullsubtractor_8bit u_sub (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .bin  (brw_q),
    .d    (sd),
    .bout (sbout)
  );

  assign idle       = state_q == IDLE;
  assign gnt0       = req0_valid & (~req1_valid | last_q);
  assign gnt1       = req1_valid & (~req0_valid | ~last_q);
  // Gated by rst_n so no ready can escape while reset is held.
  assign req0_ready = rst_n & idle & gnt0;
  assign req1_ready = rst_n & idle & gnt1;
  assign last_byte  = cnt_q == CW'(NBYTES - 1);
  assign res_valid  = state_q == DONE;
  assign res_d      = diff_q;
  assign res_bout   = bout_q;
  assign res_id     = id_q;
  assign busy       = ~idle;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    id_d    = id_q;
    if (req0_ready | req1_ready) begin
      state_d = RUN;
      a_d     = req1_ready ? req1_a : req0_a;
      b_d     = req1_ready ? req1_b : req0_b;
      brw_d   = req1_ready ? req1_bin : req0_bin;
      id_d    = req1_ready;
      last_d  = req1_ready;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      diff_d[cnt_q] = sd;
      brw_d         = sbout;
      cnt_d         = last_byte ? '0 : cnt_q + CW'(1);
      bout_d        = last_byte ? sbout : bout_q;
      state_d       = last_byte ? DONE : RUN;
    end else if (res_valid & res_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      id_q    <= id_d;
    end
  end
endmodule

// File: tb/tb_sub_serial_arbiter.sv
// tb_sub_serial_arbiter: directed scenarios for the shared serial subtractor arbiter.
module tb_sub_serial_arbiter;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 0, rst_n = 0;
  logic         req0_valid = 0, req0_bin = 0, req1_valid = 0, req1_bin = 0, res_ready = 1;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic         req0_ready, req1_ready, res_valid, res_bout, res_id, busy;
  logic [W-1:0] res_d;
  int total = 0, bad = 0;

  sub_serial_arbiter #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_bin(req0_bin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_bin(req1_bin),
    .res_valid(res_valid), .res_ready(res_ready), .res_d(res_d), .res_bout(res_bout), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pending requests must hold their operands until accepted.
  logic pend0 = 0, pend1 = 0;
  logic [2*W:0] prev0, prev1;
  always @(posedge clk) begin
    if (rst_n && pend0 && req0_valid && {req0_a, req0_b, req0_bin} !== prev0) begin
      bad <= bad + 1; $display("FAIL proto0 operands changed while pending");
    end
    if (rst_n && pend1 && req1_valid && {req1_a, req1_b, req1_bin} !== prev1) begin
      bad <= bad + 1; $display("FAIL proto1 operands changed while pending");
    end
    pend0 <= req0_valid & ~req0_ready;
    pend1 <= req1_valid & ~req1_ready;
    prev0 <= {req0_a, req0_b, req0_bin};
    prev1 <= {req1_a, req1_b, req1_bin};
  end

  task automatic reset_dut();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (res_valid !== 0) begin bad++; $display("FAIL rst_valid got=%0b want=0", res_valid); end
    total++; if (busy !== 0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", {req0_ready, req1_ready}); end
    total++; if ({res_d, res_bout, res_id} !== '0) begin bad++; $display("FAIL rst_res got=%h/%0b/%0b want=0", res_d, res_bout, res_id); end
    reset_dut();
  endtask

  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit bin,
                       input logic [W-1:0] ed, input bit eb, input string nm);
    int n;
    res_ready = 1;
    if (id) begin req1_a = a; req1_b = b; req1_bin = bin; req1_valid = 1; end
    else begin req0_a = a; req0_b = b; req0_bin = bin; req0_valid = 1; end
    #1;
    total++; if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin bad++; $display("FAIL %s grant got=%b want=%b", nm, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01); end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    total++; if ({busy, req1_ready, req0_ready} !== 3'b100) begin bad++; $display("FAIL %s accept busy/rdy got=%b want=100", nm, {busy, req1_ready, req0_ready}); end
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (n !== NB) begin bad++; $display("FAIL %s latency got=%0d want=%0d", nm, n, NB); end
    total++; if (res_d !== ed) begin bad++; $display("FAIL %s d got=%h want=%h", nm, res_d, ed); end
    total++; if ({res_bout, res_id} !== {eb, id}) begin bad++; $display("FAIL %s bout/id got=%b want=%b", nm, {res_bout, res_id}, {eb, id}); end
    @(posedge clk); #1;
    total++; if ({res_valid, busy} !== 2'b00) begin bad++; $display("FAIL %s release got=%b want=00", nm, {res_valid, busy}); end
  endtask

  task automatic test_basic();
    do_op(0, 32'h00000005, 32'h00000003, 0, 32'h00000002, 0, "basic0");
    do_op(1, 32'h00000000, 32'h00000001, 0, 32'hFFFFFFFF, 1, "underflow1");
  endtask

  task automatic test_borrow_ripple();
    do_op(0, 32'h00010000, 32'h00000001, 1, 32'h0000FFFE, 0, "ripple");
    do_op(1, 32'h12345678, 32'h12345678, 1, 32'hFFFFFFFF, 1, "equal_bin");
  endtask

  task automatic test_back_to_back();
    int g = 0, r = 0;
    int gc[4];
    reset_dut();
    res_ready = 1;
    req0_a = 100; req0_b = 1; req0_bin = 0;
    req1_a = 7;   req1_b = 9; req1_bin = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int c = 0; c < 80 && r < 4; c++) begin
      if (g < 4 && (req0_ready | req1_ready)) begin
        total++; if ({req1_ready, req0_ready} !== ((g % 2) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL fair grant%0d got=%b", g, {req1_ready, req0_ready}); end
        gc[g] = c; g++;
      end
      if (res_valid) begin
        total++; if (res_id !== 1'(r % 2)) begin bad++; $display("FAIL fair id%0d got=%0b want=%0d", r, res_id, r % 2); end
        total++; if ({res_d, res_bout} !== ((r % 2) ? {32'hFFFFFFFE, 1'b1} : {32'h00000063, 1'b0})) begin bad++; $display("FAIL fair res%0d got=%h/%0b", r, res_d, res_bout); end
        r++;
      end
      @(posedge clk); #1;
      if (g == 4) begin req0_valid = 0; req1_valid = 0; end
    end
    total++; if (r !== 4) begin bad++; $display("FAIL fair results got=%0d want=4", r); end
    for (int i = 0; i < 3; i++) begin
      total++; if (i + 1 < g && gc[i+1] - gc[i] !== NB + 2) begin bad++; $display("FAIL fair spacing%0d got=%0d want=%0d", i, gc[i+1] - gc[i], NB + 2); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [W-1:0] d0;
    res_ready = 0;
    req0_a = 32'h0A0B0C0D; req0_b = 32'h01010101; req0_bin = 0; req0_valid = 1;
    @(posedge clk); #1;
    req0_valid = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (res_valid !== 1) begin bad++; $display("FAIL bp valid timeout got=%0b want=1", res_valid); end
    d0 = res_d;
    total++; if (d0 !== 32'h090A0B0C) begin bad++; $display("FAIL bp d got=%h want=090a0b0c", d0); end
    req1_a = 2; req1_b = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if ({res_valid, res_id, req0_ready, req1_ready} !== 4'b1000 || res_d !== d0) begin bad++; $display("FAIL bp hold%0d got=%b/%h", i, {res_valid, res_id, req0_ready, req1_ready}, res_d); end
    end
    res_ready = 1;
    @(posedge clk); #1;
    total++; if ({res_valid, busy, req1_ready, req0_ready} !== 4'b0010) begin bad++; $display("FAIL bp release got=%b want=0010", {res_valid, busy, req1_ready, req0_ready}); end
    req0_valid = 0; req1_valid = 0;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL bp drop got=%b want=00", {req1_ready, req0_ready}); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1;
    req1_a = 32'hFFFFFFFF; req1_b = 0; req1_bin = 0; req1_valid = 1;
    @(posedge clk); #1;
    req1_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 0; req0_a = 5; req0_b = 1; req0_valid = 1;
    #1;
    total++; if ({busy, res_valid, req0_ready, req1_ready} !== 4'b0000) begin bad++; $display("FAIL midrst ctl got=%b want=0000", {busy, res_valid, req0_ready, req1_ready}); end
    total++; if ({res_d, res_bout, res_id} !== '0) begin bad++; $display("FAIL midrst res got=%h/%0b/%0b want=0", res_d, res_bout, res_id); end
    repeat (2) @(posedge clk);
    #1;
    total++; if ({res_valid, req0_ready} !== 2'b00) begin bad++; $display("FAIL midrst held got=%b want=00", {res_valid, req0_ready}); end
    req0_valid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    total++; if ({res_valid, busy} !== 2'b00) begin bad++; $display("FAIL midrst after got=%b want=00", {res_valid, busy}); end
    do_op(0, 32'h00000100, 32'h00000001, 0, 32'h000000FF, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sub_serial_arbiter.md
Name: sub_serial_arbiter

Overview:
- Shares one fullsubtractor_8bit instance between two requesters.
- Each requester submits a wide unsigned subtraction (8*NBYTES bits) with a borrow-in.
- The block arbitrates round-robin and executes the operation byte-serially, LSB first, carrying the borrow in a register.
- Sits between client engines and the byte subtractor datapath; the result is returned over a valid/ready channel tagged with the requester ID.

Parameters:
- NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 1..16

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  W  minuend, requester 0
- req0_b  input  W  subtrahend, requester 0
- req0_bin  input  1  borrow-in, requester 0
- req1_valid  input  1  requester 1 has an operation
- req1_ready  output  1  requester 1 operation accepted this cycle
- req1_a  input  W  minuend, requester 1
- req1_b  input  W  subtrahend, requester 1
- req1_bin  input  1  borrow-in, requester 1
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_d  output  W  difference a-b-bin mod 2^W
- res_bout  output  1  final borrow-out (1 iff a < b+bin, unsigned)
- res_id  output  1  requester that owns the result
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE; res_valid=0, res_d=0, res_bout=0, res_id=0.
  - req*_ready=0, busy=0; byte counter=0, borrow reg=0.
  - last_grant=1, so req0 wins the first tie.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant is combinational: only one valid -> that requester; both valid -> the requester != last_grant; none -> stay.
  - reqX_ready=1 only in IDLE and only for the granted X; never both.
  - Transfer on reqX_valid & reqX_ready edge: latch a, b, bin and res_id=X; last_grant<=X; counter<=0; borrow<=bin; go to RUN.
- RUN:
  - Each cycle drives byte k=counter of latched a/b plus the borrow reg into the subtractor (bin port; its own bin chaining is used as the internal byte path).
  - Writes d into res_d[8k+7:8k]; borrow<=bout; counter++.
  - After byte NBYTES-1: res_bout<=bout, go to DONE.
  - Exactly NBYTES RUN cycles; res_valid rises NBYTES edges after the acceptance edge.
- DONE:
  - res_valid=1; res_d/res_bout/res_id stable until res_valid & res_ready.
  - On that edge: res_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle (one IDLE cycle minimum between operations).
- Protocol rules:
  - reqX_valid and operands must stay stable until ready; the bench asserts this.
  - A request that drops valid before grant is simply not served.
- Backpressure: while in RUN/DONE both ready=0 regardless of valid.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…; no requester waits more than one operation.
- Reset mid-operation: immediately returns to reset values; the in-flight operation is discarded, no result issued, no ready pulse.
- res_d bytes not yet written during RUN are don't-care; only sampled when res_valid=1.

Test Plan (NBYTES=4):
- req0 a=0x00000005 b=0x00000003 bin=0 -> req0_ready one cycle; res_valid 4 edges later; d=0x00000002, bout=0, id=0.
- req1 a=0x00000000 b=0x00000001 bin=0 -> d=0xFFFFFFFF, bout=1, id=1.
- Borrow ripple across bytes: req0 a=0x00010000 b=0x00000001 bin=1 -> d=0x0000FFFE, bout=0. Also a=0x12345678 b=0x12345678 bin=1 -> d=0xFFFFFFFF, bout=1.
- Both valid continuously for 4 ops from reset with res_ready=1 -> grant order 0,1,0,1; res_id sequence 0,1,0,1; each op spaced NBYTES+2 cycles.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid/res_d/res_id stable, req0_ready and req1_ready stay 0; release -> IDLE next cycle.
- Assert rst_n low during RUN byte 2 -> all outputs 0 asynchronously, no result; after release, req0 a=0x00000100 b=0x00000001 bin=0 -> d=0x000000FF, bout=0, id=0.
